// File: rtl/pe_driver_pkg.sv
// Shared types for the pe_driver slice (package pe_pkg).
package pe_pkg;

  localparam int unsigned PE_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pe_drv_state_e;

  typedef struct packed {
    logic                     is_weight;
    logic [PE_DATA_WIDTH-1:0] a;
    logic [PE_DATA_WIDTH-1:0] b;
  } pe_cmd_t;

  // Deliberately ignores a same-cycle response pop.
  function automatic logic credit_ok(input int unsigned inflight,
                                     input int unsigned occupancy,
                                     input int unsigned depth);
    return (inflight + occupancy) < depth;
  endfunction

endpackage

// File: rtl/pe_driver_if.sv
// Command and response valid/ready streams of pe_driver.
interface pe_driver_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_is_weight;
  logic [DATA_WIDTH-1:0] cmd_a;
  logic [DATA_WIDTH-1:0] cmd_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_is_weight, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_is_weight, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/pe_driver_fifo.sv
// Response buffer: synchronous FIFO with occupancy count, async active-low reset.
module pe_driver_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_pop;

  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= (r_wr == LAST) ? '0 : r_wr + AW'(1);
      end
      if (w_pop) r_rd <= (r_rd == LAST) ? '0 : r_rd + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  end

  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/pe_driver.sv
// Initiator-side sequencer for one basic_pe: issues weight/compute commands, returns results in order.
// Optional PE_DRIVER_PERF_EN adds perf_issued / perf_stalls counters.
module pe_driver
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PE_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pe_driver_if.slave            bus,
  output logic                  store_weight,
  output logic [DATA_WIDTH-1:0] data_input,
  output logic [DATA_WIDTH-1:0] previous_result,
  input  logic [DATA_WIDTH-1:0] result,
  output logic                  weight_loaded,
  output logic                  busy
`ifdef PE_DRIVER_PERF_EN
  ,
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_stalls
`endif
);
  localparam int unsigned IW = $clog2(PE_LATENCY + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  pe_drv_state_e         r_state;
  logic [PE_LATENCY-1:0] r_sr;
  logic [IW-1:0]         r_inflight;
  logic [CW-1:0]         w_count;
  logic [DATA_WIDTH-1:0] w_fifo_data;
  logic                  w_cmd_ready;
  logic                  w_credit;
  logic                  w_acc_w;
  logic                  w_acc_c;
  logic                  w_tail;
  logic                  w_pop;

  assign w_credit = credit_ok(32'(r_inflight), 32'(w_count), FIFO_DEPTH);
  assign w_tail   = r_sr[PE_LATENCY-1];

  always_comb begin
    w_cmd_ready = 1'b0;
    case (r_state)
      EMPTY:   w_cmd_ready = bus.cmd_is_weight;
      RUN:     w_cmd_ready = bus.cmd_is_weight ? (r_inflight == '0) : w_credit;
      default: w_cmd_ready = 1'b0;
    endcase
    w_cmd_ready = w_cmd_ready && bus.cmd_valid;
  end

  assign w_acc_w = w_cmd_ready && bus.cmd_is_weight;
  assign w_acc_c = w_cmd_ready && !bus.cmd_is_weight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= EMPTY;
      r_sr            <= '0;
      r_inflight      <= '0;
      store_weight    <= 1'b0;
      data_input      <= '0;
      previous_result <= '0;
      weight_loaded   <= 1'b0;
    end else begin
      store_weight <= w_acc_w;
      if (w_acc_w) begin
        data_input      <= '0;
        previous_result <= bus.cmd_b;
        weight_loaded   <= 1'b1;
      end else if (w_acc_c) begin
        data_input      <= bus.cmd_a;
        previous_result <= bus.cmd_b;
      end
      r_sr[0] <= w_acc_c;
      for (int unsigned i = 1; i < PE_LATENCY; i++) r_sr[i] <= r_sr[i-1];
      r_inflight <= r_inflight + IW'(w_acc_c) - IW'(w_tail);
      // The weight waits in DRAIN until every in-flight compute has left the PE.
      case (r_state)
        EMPTY: if (w_acc_w) r_state <= RUN;
        RUN:   if (bus.cmd_valid && bus.cmd_is_weight && (r_inflight != '0)) r_state <= DRAIN;
        DRAIN: if (r_inflight == '0) r_state <= RUN;
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign w_pop = bus.rsp_ready && bus.rsp_valid;

  pe_driver_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_tail),
    .i_data  (result),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (w_count)
  );

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.rsp_valid = (w_count != '0);
  assign bus.rsp_data  = w_fifo_data;
  assign busy          = (r_inflight != '0) || (w_count != '0);

`ifdef PE_DRIVER_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_stalls <= '0;
    end else begin
      if (w_acc_c) perf_issued <= perf_issued + 32'd1;
      if (bus.cmd_valid && !w_cmd_ready) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_driver.sv
// Self-checking bench for pe_driver with a behavioural basic_pe (result = data_input*weight + previous_result).
module tb_pe_driver;
  import pe_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          store_weight;
  logic [DW-1:0] data_input;
  logic [DW-1:0] previous_result;
  logic [DW-1:0] result;
  logic          weight_loaded;
  logic          busy;
`ifdef PE_DRIVER_PERF_EN
  logic [31:0]   perf_issued;
  logic [31:0]   perf_stalls;
`endif

  int unsigned   n_tests = 0;
  int unsigned   n_fail = 0;
  int unsigned   tb_stalls = 0;
  int unsigned   tb_issued = 0;
  logic [DW-1:0] mdl_w = '0;
  logic [DW-1:0] expq[$];

  pe_driver_if #(.DATA_WIDTH(DW)) bus ();

  pe_driver #(
    .DATA_WIDTH (DW),
    .PE_LATENCY (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .store_weight    (store_weight),
    .data_input      (data_input),
    .previous_result (previous_result),
    .result          (result),
    .weight_loaded   (weight_loaded),
    .busy            (busy)
`ifdef PE_DRIVER_PERF_EN
    ,
    .perf_issued     (perf_issued),
    .perf_stalls     (perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  // PE model: one register stage, so result is valid LAT=2 edges after the input edge.
  logic [DW-1:0] pe_w = '0;
  logic [DW-1:0] pe_r = '0;
  always @(posedge clk) begin
    if (store_weight) pe_w <= previous_result;
    pe_r <= DW'(data_input * pe_w + previous_result);
  end
  assign result = pe_r;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, required completion");
    $fatal(1, "watchdog");
  end

  // Offers one command until accepted; returns at posedge+1 of the accept edge.
  task automatic send(input bit w, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      output bit ok, output int unsigned st);
    int unsigned cyc = 0;
    ok = 1'b0;
    st = 0;
    @(negedge clk);
    bus.cmd_valid     = 1'b1;
    bus.cmd_is_weight = w;
    bus.cmd_a         = a;
    bus.cmd_b         = b;
    while (!ok && cyc < 200) begin
      #1;
      if (bus.cmd_ready) begin
        ok = 1'b1;
        if (w) mdl_w = b;
        else begin
          expq.push_back(DW'(a * mdl_w + b));
          tb_issued++;
        end
      end else begin
        st++;
        tb_stalls++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: accepted=0 required=1 (w=%0b a=%0d b=%0d)", w, a, b);
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tb_stalls = 0;
    tb_issued = 0;
    mdl_w = '0;
    expq.delete();
  endtask

  task automatic test_reset();
    int unsigned rdy = 0;
    bit ok; int unsigned st;
    #3;
    n_tests++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready: got=%0b exp=0", bus.cmd_ready); end
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got=%0b exp=0", bus.rsp_valid); end
    n_tests++; if (bus.rsp_data !== '0) begin n_fail++; $display("FAIL rst_rsp_data: got=%0h exp=0", bus.rsp_data); end
    n_tests++; if (store_weight !== 1'b0) begin n_fail++; $display("FAIL rst_store_weight: got=%0b exp=0", store_weight); end
    n_tests++; if (data_input !== '0 || previous_result !== '0) begin n_fail++; $display("FAIL rst_pe_ports: got=%0h/%0h exp=0/0", data_input, previous_result); end
    n_tests++; if (weight_loaded !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_status: got=%0b/%0b exp=0/0", weight_loaded, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    // A compute before any weight must be refused.
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_is_weight = 1'b0; bus.cmd_a = 8'd1; bus.cmd_b = 8'd1;
    repeat (5) begin
      #1;
      if (bus.cmd_ready) rdy++;
      @(negedge clk);
    end
    n_tests++; if (rdy != 0) begin n_fail++; $display("FAIL compute_before_weight: ready_cycles=%0d exp=0", rdy); end
    n_tests++; if (weight_loaded !== 1'b0) begin n_fail++; $display("FAIL weight_loaded_early: got=%0b exp=0", weight_loaded); end
    send(1'b1, 8'd0, 8'd1, ok, st);
    bus.cmd_valid = 1'b0;
    n_tests++; if (store_weight !== 1'b1 || previous_result !== 8'd1 || data_input !== 8'd0)
      begin n_fail++; $display("FAIL weight_load: got sw=%0b pr=%0d di=%0d exp sw=1 pr=1 di=0", store_weight, previous_result, data_input); end
    n_tests++; if (weight_loaded !== 1'b1) begin n_fail++; $display("FAIL weight_loaded: got=%0b exp=1", weight_loaded); end
    @(posedge clk); #1;
    n_tests++; if (store_weight !== 1'b0) begin n_fail++; $display("FAIL store_weight_pulse: got=%0b exp=0", store_weight); end
  endtask

  task automatic test_stream();
    int unsigned got = 0, cyc = 0, first_c = 0, last_c = 0, stall_after = 0;
    bus.rsp_ready = 1'b1;
    fork
      begin
        bit ok; int unsigned st;
        for (int i = 0; i < 400; i++) begin
          logic [DW-1:0] a, b;
          a = DW'($urandom_range(0, 19)) - DW'(10);
          b = DW'($urandom_range(0, 19)) - DW'(10);
          send(1'b0, a, b, ok, st);
          if (i > 0) stall_after += st;
        end
        bus.cmd_valid = 1'b0;
      end
      begin
        while (got < 400 && cyc < 1500) begin
          @(negedge clk); #2; cyc++;
          if (bus.rsp_valid) begin
            n_tests++;
            if (expq.size() == 0) begin n_fail++; $display("FAIL stream_extra: got=%0d exp=none", bus.rsp_data); end
            else begin
              logic [DW-1:0] e;
              e = expq.pop_front();
              if (bus.rsp_data !== e) begin n_fail++; $display("FAIL stream_data[%0d]: got=%0d exp=%0d", got, bus.rsp_data, e); end
            end
            if (got == 0) first_c = cyc;
            last_c = cyc;
            got++;
          end
        end
      end
    join
    n_tests++; if (got != 400) begin n_fail++; $display("FAIL stream_count: got=%0d exp=400", got); end
    n_tests++; if (stall_after != 0) begin n_fail++; $display("FAIL stream_stalls: got=%0d exp=0", stall_after); end
    n_tests++; if (last_c - first_c != 399) begin n_fail++; $display("FAIL stream_rate: span=%0d exp=399", last_c - first_c); end
  endtask

  task automatic test_drain();
    int unsigned got = 0, cyc = 0, wst = 0;
    bus.rsp_ready = 1'b1;
    fork
      begin
        bit ok; int unsigned st;
        send(1'b1, 8'd0, 8'd2, ok, st);
        send(1'b0, 8'd5, 8'd0, ok, st);
        send(1'b1, 8'd0, 8'd4, ok, wst);
        n_tests++; if (store_weight !== 1'b1 || previous_result !== 8'd4)
          begin n_fail++; $display("FAIL drain_weight_apply: got sw=%0b pr=%0d exp sw=1 pr=4", store_weight, previous_result); end
        send(1'b0, 8'd5, 8'd0, ok, st);
        bus.cmd_valid = 1'b0;
      end
      begin
        while (got < 2 && cyc < 100) begin
          @(negedge clk); #2; cyc++;
          if (bus.rsp_valid) begin
            logic [DW-1:0] e;
            e = (got == 0) ? 8'd10 : 8'd20;
            n_tests++; if (bus.rsp_data !== e) begin n_fail++; $display("FAIL drain_rsp[%0d]: got=%0d exp=%0d", got, bus.rsp_data, e); end
            if (expq.size() != 0) void'(expq.pop_front());
            got++;
          end
        end
      end
    join
    n_tests++; if (got != 2) begin n_fail++; $display("FAIL drain_count: got=%0d exp=2", got); end
    n_tests++; if (wst != LAT + 1) begin n_fail++; $display("FAIL drain_bubble: got=%0d exp=%0d", wst, LAT + 1); end
    repeat (2) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drain_idle_busy: got=%0b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int unsigned seen = 0, rdy = 0;
    bit ok; int unsigned st;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, DW'(i + 1), 8'd1, ok, st);
    bus.cmd_valid = 1'b0;
    n_tests++; if (busy !== 1'b1 || bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_loaded: got busy=%0b rv=%0b exp 1/1", busy, bus.rsp_valid); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0 || busy !== 1'b0 || bus.cmd_ready !== 1'b0)
      begin n_fail++; $display("FAIL mid_rst_rsp: got rv=%0b rd=%0h busy=%0b cr=%0b exp all 0", bus.rsp_valid, bus.rsp_data, busy, bus.cmd_ready); end
    n_tests++; if (store_weight !== 1'b0 || data_input !== '0 || previous_result !== '0 || weight_loaded !== 1'b0)
      begin n_fail++; $display("FAIL mid_rst_pe: got sw=%0b di=%0h pr=%0h wl=%0b exp all 0", store_weight, data_input, previous_result, weight_loaded); end
    expq.delete();
    mdl_w = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    repeat (8) begin
      @(negedge clk); #2;
      if (bus.rsp_valid) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL mid_stale_rsp: valid_cycles=%0d exp=0", seen); end
    bus.cmd_valid = 1'b1; bus.cmd_is_weight = 1'b0; bus.cmd_a = 8'd1; bus.cmd_b = 8'd1;
    repeat (3) begin
      #1;
      if (bus.cmd_ready) rdy++;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    n_tests++; if (rdy != 0 || weight_loaded !== 1'b0) begin n_fail++; $display("FAIL mid_state_empty: ready_cycles=%0d wl=%0b exp 0/0", rdy, weight_loaded); end
  endtask

  task automatic test_backpressure();
    int unsigned acc = 0, got = 0, cyc = 0, unstable = 0;
    bit ok; int unsigned st;
    do_reset();
    send(1'b1, 8'd0, 8'd3, ok, st);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    fork
      begin
        bit ok2; int unsigned st2;
        for (int i = 0; i < 6; i++) begin
          send(1'b0, 8'd2, 8'd1, ok2, st2);
          if (ok2) acc++;
        end
        bus.cmd_valid = 1'b0;
      end
      begin
        repeat (12) @(negedge clk);
        #2;
        n_tests++; if (acc != 4) begin n_fail++; $display("FAIL bp_accepted: got=%0d exp=4", acc); end
        n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'd7) begin n_fail++; $display("FAIL bp_head: got rv=%0b rd=%0d exp 1/7", bus.rsp_valid, bus.rsp_data); end
        repeat (4) begin
          @(negedge clk); #2;
          if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'd7) unstable++;
        end
        n_tests++; if (unstable != 0) begin n_fail++; $display("FAIL bp_hold: unstable_cycles=%0d exp=0", unstable); end
        bus.rsp_ready = 1'b1;
        while (got < 6 && cyc < 100) begin
          if (bus.rsp_valid) begin
            n_tests++;
            if (expq.size() == 0) begin n_fail++; $display("FAIL bp_extra: got=%0d exp=none", bus.rsp_data); end
            else begin
              logic [DW-1:0] e;
              e = expq.pop_front();
              if (bus.rsp_data !== e) begin n_fail++; $display("FAIL bp_rsp[%0d]: got=%0d exp=%0d", got, bus.rsp_data, e); end
            end
            got++;
          end
          @(negedge clk); #2; cyc++;
        end
      end
    join
    n_tests++; if (got != 6) begin n_fail++; $display("FAIL bp_count: got=%0d exp=6", got); end
`ifdef PE_DRIVER_PERF_EN
    n_tests++; if (perf_issued !== 32'd6) begin n_fail++; $display("FAIL perf_issued: got=%0d exp=6", perf_issued); end
    n_tests++; if (perf_stalls !== 32'(tb_stalls)) begin n_fail++; $display("FAIL perf_stalls: got=%0d exp=%0d", perf_stalls, tb_stalls); end
`endif
  endtask

  initial begin
    bus.cmd_valid     = 1'b0;
    bus.cmd_is_weight = 1'b0;
    bus.cmd_a         = '0;
    bus.cmd_b         = '0;
    bus.rsp_ready     = 1'b0;
    test_reset();
    test_stream();
    test_drain();
    test_reset_mid();
    test_backpressure();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
